link_control: RTL and testbench

Upstream control FSM for the player-character datapath. It runs once per video frame:
- samples the debounced direction and attack buttons,
- checks Link's current position against the map bounds,
- issues exactly one one-hot command (init, idle, attack, move_*, draw_char) to the character datapath,
- holds draw_char until the datapath returns draw_done, or a timeout fires.

It sits between the input debouncers / frame timer and the character movement datapath.

---
 rtl/link_control_if.sv | 40 ++++
 rtl/link_control.sv | 147 ++++++++++++++
 tb/tb_link_control.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/link_control_if.sv
// Signal bundle between link_control and its neighbours: frame timer,
// debounced buttons and Link position in; one-hot commands and the sticky
// draw error out to the character datapath.
interface link_control_if;
   logic       frame_tick;
   logic       key_up;
   logic       key_down;
   logic       key_left;
   logic       key_right;
   logic       key_attack;
   logic [7:0] link_x;
   logic [7:0] link_y;
   logic       draw_done;

   logic       init;
   logic       idle;
   logic       attack;
   logic       move_up;
   logic       move_down;
   logic       move_left;
   logic       move_right;
   logic       draw_char;
   logic       draw_err;

   // Environment side: drives timer, buttons, position and draw_done.
   modport master (
      output frame_tick, key_up, key_down, key_left, key_right, key_attack,
             link_x, link_y, draw_done,
      input  init, idle, attack, move_up, move_down, move_left, move_right,
             draw_char, draw_err
   );

   // Controller side.
   modport slave (
      input  frame_tick, key_up, key_down, key_left, key_right, key_attack,
             link_x, link_y, draw_done,
      output init, idle, attack, move_up, move_down, move_left, move_right,
             draw_char, draw_err
   );
endinterface

// File: rtl/link_control.sv
// link_control: once-per-frame control FSM for the player character.
// Waits MOVE_DIV frame ticks, decides one action from the buttons and the
// map bounds, issues a one-cycle command, then holds draw_char until the
// datapath answers draw_done or the DRAW watchdog expires.
module link_control #(
   parameter int MOVE_DIV      = 1,     // frame ticks per decision, 1..15
   parameter int ATTACK_FRAMES = 8,     // decisions per attack, 1..15
   parameter int DRAW_TIMEOUT  = 4095   // last DRAW cycle before abort
) (
   input logic          clock,
   input logic          reset,
   link_control_if.slave bus
);

   localparam logic [3:0] ST_RST    = 4'd0;
   localparam logic [3:0] ST_INIT   = 4'd1;
   localparam logic [3:0] ST_DRAW   = 4'd2;
   localparam logic [3:0] ST_WAIT   = 4'd3;
   localparam logic [3:0] ST_DECIDE = 4'd4;
   localparam logic [3:0] ST_ATTACK = 4'd5;
   localparam logic [3:0] ST_MOVE_U = 4'd6;
   localparam logic [3:0] ST_MOVE_D = 4'd7;
   localparam logic [3:0] ST_MOVE_L = 4'd8;
   localparam logic [3:0] ST_MOVE_R = 4'd9;

   localparam logic [3:0]  MOVE_LAST  = 4'(MOVE_DIV - 1);
   localparam logic [3:0]  ATK_LOAD   = 4'(ATTACK_FRAMES - 1);
   localparam logic [11:0] DRAW_LIMIT = 12'(DRAW_TIMEOUT);

   // 16x16 sprite on a 256x176 map: last legal top-left is (240, 160).
   localparam logic [7:0]  X_LIMIT = 8'd240;
   localparam logic [7:0]  Y_LIMIT = 8'd160;

   logic [3:0]  state,      state_nxt;
   logic [3:0]  frame_cnt,  frame_cnt_nxt;
   logic [3:0]  atk_cnt,    atk_cnt_nxt;
   logic [11:0] draw_cnt,   draw_cnt_nxt;
   logic        draw_err_q, draw_err_nxt;

   // Next-state and counter logic.
   // NOTE: every variable gets a default at the top so no path leaves it
   // unassigned; otherwise synthesis would infer a latch to hold the value.
   always_comb begin
      state_nxt     = state;
      frame_cnt_nxt = frame_cnt;
      atk_cnt_nxt   = atk_cnt;
      draw_cnt_nxt  = '0;          // held at zero outside DRAW, so entry clears it
      draw_err_nxt  = draw_err_q;

      case (state)
         ST_RST:  state_nxt = ST_INIT;
         ST_INIT: state_nxt = ST_DRAW;

         ST_DRAW: begin
            if (bus.draw_done) begin
               state_nxt = ST_WAIT;     // done wins over a same-cycle timeout
            end else if (draw_cnt == DRAW_LIMIT) begin
               state_nxt    = ST_WAIT;
               draw_err_nxt = 1'b1;
            end else begin
               draw_cnt_nxt = draw_cnt + 12'd1;
            end
         end

         ST_WAIT: begin
            if (bus.frame_tick) begin
               if (frame_cnt == MOVE_LAST) begin
                  frame_cnt_nxt = '0;
                  state_nxt     = ST_DECIDE;
               end else begin
                  frame_cnt_nxt = frame_cnt + 4'd1;
               end
            end
         end

         ST_DECIDE: begin
            if (atk_cnt != 4'd0) begin
               atk_cnt_nxt = atk_cnt - 4'd1;
               state_nxt   = ST_ATTACK;
            end else if (bus.key_attack) begin
               atk_cnt_nxt = ATK_LOAD;
               state_nxt   = ST_ATTACK;
            end else if (bus.key_up && bus.link_y != 8'd0) begin
               state_nxt = ST_MOVE_U;
            end else if (bus.key_down && bus.link_y < Y_LIMIT) begin
               state_nxt = ST_MOVE_D;
            end else if (bus.key_left && bus.link_x != 8'd0) begin
               state_nxt = ST_MOVE_L;
            end else if (bus.key_right && bus.link_x < X_LIMIT) begin
               state_nxt = ST_MOVE_R;
            end else begin
               state_nxt = ST_WAIT;     // nothing to do: skip the redraw
            end
         end

         ST_ATTACK, ST_MOVE_U, ST_MOVE_D, ST_MOVE_L, ST_MOVE_R:
            state_nxt = ST_DRAW;

         default: state_nxt = ST_RST;
      endcase
   end

   // State and counter registers with synchronous reset.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= ST_RST;
         frame_cnt  <= '0;
         atk_cnt    <= '0;
         draw_cnt   <= '0;
         draw_err_q <= 1'b0;
      end else begin
         state      <= state_nxt;
         frame_cnt  <= frame_cnt_nxt;
         atk_cnt    <= atk_cnt_nxt;
         draw_cnt   <= draw_cnt_nxt;
         draw_err_q <= draw_err_nxt;
      end
   end

   // Registered one-hot command decode, aligned with the state register.
   always_ff @(posedge clock) begin
      if (reset) begin
         bus.init       <= 1'b0;
         bus.idle       <= 1'b0;
         bus.attack     <= 1'b0;
         bus.move_up    <= 1'b0;
         bus.move_down  <= 1'b0;
         bus.move_left  <= 1'b0;
         bus.move_right <= 1'b0;
         bus.draw_char  <= 1'b0;
      end else begin
         bus.init       <= (state_nxt == ST_INIT);
         bus.idle       <= (state_nxt == ST_WAIT);
         bus.attack     <= (state_nxt == ST_ATTACK);
         bus.move_up    <= (state_nxt == ST_MOVE_U);
         bus.move_down  <= (state_nxt == ST_MOVE_D);
         bus.move_left  <= (state_nxt == ST_MOVE_L);
         bus.move_right <= (state_nxt == ST_MOVE_R);
         bus.draw_char  <= (state_nxt == ST_DRAW);
      end
   end

   assign bus.draw_err = draw_err_q;

endmodule

// File: tb/tb_link_control.sv
// Bench for link_control. Main instance (MOVE_DIV=1) is driven through a
// scoreboard: each frame tick pushes the expected command, the monitor pops
// it two cycles later when the command appears. A second instance with
// MOVE_DIV=3 checks the tick divider and tick dropping during DRAW.
module tb_link_control;

   localparam int TIMEOUT = 4095;

   typedef enum int {
      C_NONE = 0, C_INIT, C_IDLE, C_ATTACK, C_UP, C_DOWN, C_LEFT, C_RIGHT,
      C_DRAW, C_MULTI
   } cmd_e;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   link_control_if bus ();
   link_control_if bus3 ();

   link_control #(.MOVE_DIV(1), .ATTACK_FRAMES(8), .DRAW_TIMEOUT(TIMEOUT)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   link_control #(.MOVE_DIV(3), .ATTACK_FRAMES(8), .DRAW_TIMEOUT(TIMEOUT)) dut3 (
      .clock (clock),
      .reset (reset),
      .bus   (bus3.slave)
   );

   int checks   = 0;
   int failures = 0;
   int exp_q[$];
   int age1 = 0, age2 = 0;
   int mr_cnt = 0, md3_cnt = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic int cmd_code();
      logic [7:0] v;
      v = {bus.init, bus.idle, bus.attack, bus.move_up, bus.move_down,
           bus.move_left, bus.move_right, bus.draw_char};
      if ($countones(v) > 1) return C_MULTI;
      if (bus.init)       return C_INIT;
      if (bus.idle)       return C_IDLE;
      if (bus.attack)     return C_ATTACK;
      if (bus.move_up)    return C_UP;
      if (bus.move_down)  return C_DOWN;
      if (bus.move_left)  return C_LEFT;
      if (bus.move_right) return C_RIGHT;
      if (bus.draw_char)  return C_DRAW;
      return C_NONE;
   endfunction

   // Monitor: one-hot check every cycle, scoreboard pop two cycles after a tick.
   always @(negedge clock) begin
      if (!reset) begin
         check("onehot", cmd_code() != C_MULTI, 1);
         if (age2 != 0) begin
            if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
            else                   check("decide_cmd", cmd_code(), exp_q.pop_front());
         end
         if (bus.move_right) mr_cnt++;
         if (bus3.move_down) md3_cnt++;
      end
      age2 = age1;
      age1 = int'(bus.frame_tick);
   end

   // Datapath stand-in for the MOVE_DIV=3 instance: answers every draw at once.
   initial begin
      bus3.draw_done = 1'b0;
      forever begin
         @(posedge clock);
         #1;
         bus3.draw_done = bus3.draw_char && !bus3.draw_done;
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Hold draw_done back for lat cycles after DRAW starts (lat<0: never).
   task automatic serve_draw(input int lat, output int len);
      len = 0;
      for (int i = 0; i < 5000 && bus.draw_char; i++) begin
         len++;
         bus.draw_done = (len - 1 == lat);
         step();
         bus.draw_done = 1'b0;
      end
      check("draw_ended", bus.draw_char, 0);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 6000 && !bus.idle; i++) step();
      check("idle_reached", bus.idle, 1);
      step();
   endtask

   task automatic restart(input int lat);
      int len;
      reset = 1'b1;
      step();
      check("rst_cmd", cmd_code(), C_NONE);
      check("rst_err", bus.draw_err, 0);
      step();
      reset = 1'b0;
      step();
      check("init", cmd_code(), C_INIT);
      step();
      check("draw_after_init", cmd_code(), C_DRAW);
      serve_draw(lat, len);
      check("init_draw_len", len, lat + 1);
      check("idle_after_draw", cmd_code(), C_IDLE);
   endtask

   // One decision: tick in WAIT, expect cmd two cycles later, then the draw.
   task automatic frame(input int exp, input int lat);
      int len;
      wait_idle();
      exp_q.push_back(exp);
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      step();
      step();
      check("draw_follows", bus.draw_char, exp != C_IDLE);
      if (exp != C_IDLE) begin
         serve_draw(lat, len);
         check("draw_len", len, (lat < 0) ? TIMEOUT + 1 : lat + 1);
      end
   endtask

   initial begin
      int mr0, md0;
      bus.frame_tick = 1'b0;  bus.draw_done = 1'b0;
      bus.key_up = 1'b0;      bus.key_down = 1'b0;
      bus.key_left = 1'b0;    bus.key_right = 1'b0;  bus.key_attack = 1'b0;
      bus.link_x = 8'd100;    bus.link_y = 8'd80;
      bus3.frame_tick = 1'b0; bus3.key_up = 1'b0;    bus3.key_down = 1'b1;
      bus3.key_left = 1'b0;   bus3.key_right = 1'b0; bus3.key_attack = 1'b0;
      bus3.link_x = 8'd100;   bus3.link_y = 8'd80;

      // Reset release, draw_done five cycles into the first DRAW.
      step();
      restart(5);
      repeat (3) frame(C_IDLE, 0);

      // Walking right, three decisions.
      bus.key_right = 1'b1;
      mr0 = mr_cnt;
      repeat (3) frame(C_RIGHT, 2);
      check("mr_pulses", mr_cnt - mr0, 3);
      bus.key_right = 1'b0;

      // Blocked up falls through to left; all blocked gives no command.
      bus.key_up = 1'b1; bus.key_left = 1'b1;
      bus.link_y = 8'd0; bus.link_x = 8'd50;
      frame(C_LEFT, 1);
      bus.link_x = 8'd0;
      frame(C_IDLE, 0);
      bus.key_up = 1'b0; bus.key_left = 1'b0;

      // Bottom and right edges.
      bus.link_x = 8'd100; bus.key_down = 1'b1;
      bus.link_y = 8'd160; frame(C_IDLE, 0);
      bus.link_y = 8'd159; frame(C_DOWN, 1);
      bus.key_down = 1'b0; bus.key_right = 1'b1;
      bus.link_x = 8'd240; frame(C_IDLE, 0);
      bus.link_x = 8'd239; frame(C_RIGHT, 1);
      bus.key_right = 1'b0;

      // Attack lasts eight decisions and masks the held down key.
      bus.link_x = 8'd100; bus.link_y = 8'd80;
      bus.key_down = 1'b1; bus.key_attack = 1'b1;
      frame(C_ATTACK, 1);
      bus.key_attack = 1'b0;
      repeat (7) frame(C_ATTACK, 1);
      frame(C_DOWN, 1);

      // Reset in the middle of an attack cancels the rest of it.
      bus.key_attack = 1'b1;
      frame(C_ATTACK, 1);
      bus.key_attack = 1'b0;
      frame(C_ATTACK, 1);
      restart(3);
      frame(C_DOWN, 1);
      bus.key_down = 1'b0;

      // draw_done on the timeout cycle wins; then a real timeout.
      bus.key_right = 1'b1;
      frame(C_RIGHT, TIMEOUT);
      check("err_tie", bus.draw_err, 0);
      frame(C_RIGHT, -1);
      check("err_set", bus.draw_err, 1);
      check("idle_after_to", cmd_code(), C_IDLE);
      bus.key_right = 1'b0;
      bus.draw_done = 1'b1;
      step();
      bus.draw_done = 1'b0;
      step();
      check("late_done_ignored", cmd_code(), C_IDLE);
      check("err_sticky", bus.draw_err, 1);
      restart(2);

      // MOVE_DIV=3 instance: one move per three ticks, DRAW ticks dropped.
      repeat (4) step();
      md0 = md3_cnt;
      for (int t = 1; t <= 9; t++) begin
         bus3.frame_tick = 1'b1;
         step();
         bus3.frame_tick = 1'b0;
         step();
         check("d3_move", bus3.move_down, (t % 3) == 0);
         if ((t % 3) == 0) begin
            step();
            check("d3_draw", bus3.draw_char, 1);
            bus3.frame_tick = 1'b1;
            step();
            bus3.frame_tick = 1'b0;
            step();
            step();
         end else begin
            repeat (4) step();
         end
      end
      check("d3_moves", md3_cnt - md0, 3);

      check("sb_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
